// File: rtl/if_queue.sv
// Instruction fetch queue: a small FIFO of {pc, inst} pairs between the
// fetch and decode stages. Fetch pushes when in_ready is high, decode pops
// the head whenever it is valid and not stalled. Flush discards everything.
module if_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_inst,
  output logic        in_ready,
  input  logic        flush,
  input  logic        id_stall,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  // Entry storage; never reset, only observable through id_* while valid.
  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;

  logic push;
  logic pop;

  // Handshake flags derived purely from the registered count: no bypass
  // when full and no pass-through when empty.
  always_comb begin
    in_ready = (count_q < FULL_CNT);
    id_valid = (count_q != '0);
    push     = in_valid & in_ready;
    pop      = id_valid & ~id_stall;
  end

  // Head entry presented to decode, NOP when the queue is empty.
  always_comb begin
    id_pc   = '0;
    id_inst = '0;
    if (id_valid) begin
      id_pc   = pc_mem[rd_ptr_q];
      id_inst = inst_mem[rd_ptr_q];
    end
  end

  // Next-state pointers and count; flush overrides push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Write accepted instructions into storage; a flushed push is dropped.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem[wr_ptr_q]   <= in_pc;
      inst_mem[wr_ptr_q] <= in_inst;
    end
  end

endmodule

// File: tb/tb_if_queue.sv
// Self-checking bench for if_queue: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_if_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        in_ready;
  logic        flush;
  logic        id_stall;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  if_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_pc    (in_pc),
    .in_inst  (in_inst),
    .in_ready (in_ready),
    .flush    (flush),
    .id_stall (id_stall),
    .id_valid (id_valid),
    .id_pc    (id_pc),
    .id_inst  (id_inst)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t mq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare all DUT outputs with what the model queue implies.
  task automatic check_outputs(input string tag);
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    exp_valid = (mq.size() != 0);
    exp_pc    = exp_valid ? mq[0].pc   : 32'h0;
    exp_inst  = exp_valid ? mq[0].inst : 32'h0;
    chk({tag, ".in_ready"}, {31'b0, in_ready}, {31'b0, mq.size() < DEPTH});
    chk({tag, ".id_valid"}, {31'b0, id_valid}, {31'b0, exp_valid});
    chk({tag, ".id_pc"},    id_pc,    exp_pc);
    chk({tag, ".id_inst"},  id_inst,  exp_inst);
  endtask

  // One clock: drive inputs, advance the model at the edge, check 1ns later.
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [31:0] pc, input logic [31:0] inst,
                      input logic f, input logic s);
    int  sz;
    logic do_pop, do_push;
    rst = r; in_valid = v; in_pc = pc; in_inst = inst; flush = f; id_stall = s;
    @(posedge clk);
    sz      = mq.size();
    do_pop  = (sz != 0) && !s;
    do_push = v && (sz < DEPTH);
    if (r || f) begin
      mq.delete();
    end else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back('{pc: pc, inst: inst});
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  logic [31:0] inst_tab [3];
  logic [31:0] rpc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; flush = 1'b0; id_stall = 1'b0;
    inst_tab[0] = 32'h34011100;
    inst_tab[1] = 32'h34020020;
    inst_tab[2] = 32'h3403ff00;

    // Reset state.
    step("reset", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("reset_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_pc", id_pc, 32'h0);

    // Three pushes, decode free-running.
    for (int i = 0; i < 3; i++)
      step("seq3", 1'b0, 1'b1, 32'(i * 4), inst_tab[i], 1'b0, 1'b0);
    idle("seq3_drain", 3);
    chk("seq3_empty", {31'b0, id_valid}, 32'd0);

    // Stalled decode, five pushes: fifth refused.
    for (int i = 0; i < 5; i++) begin
      step("fill", 1'b0, 1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b0, 1'b1);
      if (i == 3) chk("full_ready_low", {31'b0, in_ready}, 32'd0);
    end
    chk("full_head_pc", id_pc, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step("release", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      if (i < 3) chk("release_order", id_pc, 32'((i + 1) * 4));
    end
    chk("release_empty", {31'b0, id_valid}, 32'd0);

    // Full queue, pop plus attempted push: push refused, count drops to 3.
    for (int i = 0; i < 4; i++)
      step("refill", 1'b0, 1'b1, 32'h40 + 32'(i * 4), 32'hB000_0000 + 32'(i), 1'b0, 1'b1);
    step("full_pop", 1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("full_pop_ready", {31'b0, in_ready}, 32'd1);
    chk("full_pop_head", id_pc, 32'h44);
    idle("full_pop_drain", 4);

    // Flush with a concurrent push: both queued entries and the push vanish.
    step("pre_flush", 1'b0, 1'b1, 32'h80, 32'h1111_1111, 1'b0, 1'b1);
    step("pre_flush", 1'b0, 1'b1, 32'h84, 32'h2222_2222, 1'b0, 1'b1);
    step("flush", 1'b0, 1'b1, 32'h100, 32'h3333_3333, 1'b1, 1'b1);
    chk("flush_valid", {31'b0, id_valid}, 32'd0);
    chk("flush_inst", id_inst, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step("post_flush", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("no_0x100", {31'b0, id_pc == 32'h100}, 32'd0);
    end

    // Streaming push/pop for 10 cycles across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      step("stream", 1'b0, 1'b1, 32'(i * 4), 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
      chk("stream_pc", id_pc, 32'(i * 4));
    end
    idle("stream_drain", 2);

    // Reset mid-operation with stall and three entries queued.
    for (int i = 0; i < 3; i++)
      step("pre_rst", 1'b0, 1'b1, 32'h300 + 32'(i * 4), 32'hE000_0000, 1'b0, 1'b1);
    step("mid_rst", 1'b1, 1'b1, 32'h400, 32'hF000_0000, 1'b0, 1'b1);
    chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_rst_valid", {31'b0, id_valid}, 32'd0);
    chk("mid_rst_pc", id_pc, 32'h0);

    // Random traffic.
    rpc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      logic r, v, f, s;
      r = ($urandom_range(0, 99) < 2);
      f = ($urandom_range(0, 99) < 5);
      v = ($urandom_range(0, 99) < 65);
      s = ($urandom_range(0, 99) < 40);
      step("rand", r, v, rpc, $urandom, f, s);
      rpc = rpc + 32'd4;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
